// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the TSC instruction-fetch stage: word width,
// instruction field positions and the fetch controller state encoding.
package fetch_stage_pkg;

  localparam int unsigned FS_WORD_SIZE = 16;

  // Instruction field positions used to split the IF/ID word for control.
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned FUNC_MSB   = 5;
  localparam int unsigned FUNC_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_STALLED = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HALTED  = 3'd4
  } fetch_state_e;

  // A memory request is held in FETCH and DRAIN only.
  function automatic logic req_outstanding(input fetch_state_e st);
    return (st == ST_FETCH) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/fetch_stage_if_skid_buffer.sv
// One-entry {inst, pc} holding register used when a fetched word returns
// while decode is stalled. Clear wins over load, load wins over unload.
module if_skid_buffer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic         clear_i,
  input  logic [W-1:0] inst_i,
  input  logic [W-1:0] pc_i,
  output logic         full_o,
  output logic [W-1:0] inst_o,
  output logic [W-1:0] pc_o
);

  logic         full_q, full_d;
  logic [W-1:0] inst_q, inst_d;
  logic [W-1:0] pc_q, pc_d;

  // Next-state of the holding register from the three controls.
  always_comb begin
    full_d = full_q;
    inst_d = inst_q;
    pc_d   = pc_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      inst_d = inst_i;
      pc_d   = pc_i;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  // Holding register storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      inst_q <= '0;
      pc_q   <= '0;
    end else begin
      full_q <= full_d;
      inst_q <= inst_d;
      pc_q   <= pc_d;
    end
  end

  assign full_o = full_q;
  assign inst_o = inst_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Owns the PC, holds
// read requests to instruction memory until i_ready, buffers one word when
// decode stalls, and drains an in-flight fetch after redirect or halt.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = FS_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic                 if_id_valid,
  output logic [WORD_SIZE-1:0] if_id_inst,
  output logic [WORD_SIZE-1:0] if_id_pc,
  output logic [WORD_SIZE-1:0] if_id_npc,
  output logic [3:0]           opcode,
  output logic [5:0]           func_code,
  output logic [15:0]          num_fetch
);

  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] req_addr_q, req_addr_d;
  logic                 valid_q, valid_d;
  logic [WORD_SIZE-1:0] inst_q, inst_d;
  logic [WORD_SIZE-1:0] ifpc_q, ifpc_d;
  logic [WORD_SIZE-1:0] npc_q, npc_d;
  logic [15:0]          num_fetch_q, num_fetch_d;
  logic                 halt_seen_q, halt_seen_d;

  logic                 outstanding;
  logic                 ld_en;
  logic [WORD_SIZE-1:0] ld_inst;
  logic [WORD_SIZE-1:0] ld_pc;
  logic                 consume;
  logic                 flush;
  logic                 skid_load, skid_unload, skid_clear;
  logic                 skid_full;
  logic [WORD_SIZE-1:0] skid_inst, skid_pc;

  assign outstanding = req_outstanding(state_q);

  if_skid_buffer #(.W(WORD_SIZE)) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .inst_i   (i_data),
    .pc_i     (req_addr_q),
    .full_o   (skid_full),
    .inst_o   (skid_inst),
    .pc_o     (skid_pc)
  );

  // Fetch FSM next state, PC/request address and IF/ID update selection.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    halt_seen_d = halt_seen_q;
    ld_en       = 1'b0;
    ld_inst     = i_data;
    ld_pc       = req_addr_q;
    consume     = !stall;
    flush       = 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        req_addr_d = pc_q;
      end
      ST_FETCH: begin
        if (i_ready) begin
          if (!stall || !valid_q) begin
            ld_en      = 1'b1;
            pc_d       = pc_q + 1'b1;
            req_addr_d = pc_q + 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_STALLED;
          end
        end
      end
      ST_STALLED: begin
        if (!stall) begin
          ld_en       = skid_full;
          ld_inst     = skid_inst;
          ld_pc       = skid_pc;
          skid_unload = 1'b1;
          pc_d        = pc_q + 1'b1;
          req_addr_d  = pc_q + 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // The returning word belongs to the abandoned stream; drop it.
        if (i_ready) begin
          state_d    = halt_seen_q ? ST_HALTED : ST_FETCH;
          req_addr_d = pc_q;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Halt outranks redirect; once halting, redirects no longer matter.
    if (state_q != ST_HALTED) begin
      if (halt) begin
        halt_seen_d = 1'b1;
        flush       = 1'b1;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        state_d     = (outstanding && !i_ready) ? ST_DRAIN : ST_HALTED;
      end else if (redirect && !halt_seen_q) begin
        flush = 1'b1;
        pc_d  = redirect_pc;
        if (outstanding && !i_ready) begin
          // Memory still owes a word for the held address: wait it out.
          state_d    = ST_DRAIN;
          req_addr_d = req_addr_q;
        end else begin
          state_d    = ST_FETCH;
          req_addr_d = redirect_pc;
        end
      end
    end

    if (flush) begin
      ld_en      = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b1;
    end
  end

  // IF/ID register next state: load, or drop the word once ID takes it.
  always_comb begin
    valid_d     = valid_q;
    inst_d      = inst_q;
    ifpc_d      = ifpc_q;
    npc_d       = npc_q;
    num_fetch_d = num_fetch_q;
    if (ld_en) begin
      valid_d     = 1'b1;
      inst_d      = ld_inst;
      ifpc_d      = ld_pc;
      npc_d       = ld_pc + 1'b1;
      num_fetch_d = num_fetch_q + 16'd1;
    end else if (flush || consume) begin
      valid_d = 1'b0;
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      valid_q     <= 1'b0;
      inst_q      <= '0;
      ifpc_q      <= '0;
      npc_q       <= '0;
      num_fetch_q <= '0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      ifpc_q      <= ifpc_d;
      npc_q       <= npc_d;
      num_fetch_q <= num_fetch_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  assign i_readM     = outstanding;
  assign i_address   = req_addr_q;
  assign if_id_valid = valid_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_npc   = npc_q;
  assign num_fetch   = num_fetch_q;
  assign opcode      = inst_q[OPCODE_MSB:OPCODE_LSB];
  assign func_code   = inst_q[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable instruction memory
// model plus hand-traced stimulus and expected values.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_ready;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        if_id_valid;
  logic [15:0] if_id_inst;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_npc;
  logic [3:0]  opcode;
  logic [5:0]  func_code;
  logic [15:0] num_fetch;

  int total = 0;
  int bad   = 0;
  int mem_lat = 1;
  int mem_cnt = 0;

  fetch_stage dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_readM     (i_readM),
    .i_address   (i_address),
    .i_data      (i_data),
    .i_ready     (i_ready),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .if_id_valid (if_id_valid),
    .if_id_inst  (if_id_inst),
    .if_id_pc    (if_id_pc),
    .if_id_npc   (if_id_npc),
    .opcode      (opcode),
    .func_code   (func_code),
    .num_fetch   (num_fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: word at a = {6, a[3:0], a[7:0]+1}; 0000->6001, 0001->6102.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0] + 8'd1;
    return {4'h6, a[3:0], lo};
  endfunction

  // Memory model: counts held-request cycles, pulses i_ready for one cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      i_ready = 1'b0;
      mem_cnt = 0;
    end else if (i_ready) begin
      i_ready = 1'b0;
      mem_cnt = 0;
    end else if (i_readM) begin
      mem_cnt = mem_cnt + 1;
      if (mem_cnt >= mem_lat) begin
        i_ready = 1'b1;
        i_data  = mem_word(i_address);
        mem_cnt = 0;
        $display("mem: addr=%h data=%h t=%0t", i_address, i_data, $time);
      end
    end else begin
      mem_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    while (!if_id_valid && n < max_cycles) begin
      tick();
      n++;
    end
    chk("wait_valid_timeout", {31'd0, if_id_valid}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_readM"}, {31'd0, i_readM}, 32'd0);
    chk({tag, "_addr"}, {16'd0, i_address}, 32'h0000);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_inst"}, {16'd0, if_id_inst}, 32'h0000);
    chk({tag, "_pc"}, {16'd0, if_id_pc}, 32'h0000);
    chk({tag, "_npc"}, {16'd0, if_id_npc}, 32'h0000);
    chk({tag, "_nfetch"}, {16'd0, num_fetch}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    halt = 1'b0; i_ready = 1'b0; i_data = 16'h0000; mem_lat = 1;
    tick(); tick();
    chk_reset_outputs("rst");

    // Reset release: IDLE cycle, then first request in the second cycle.
    reset_n = 1'b1;
    chk("idle_readM", {31'd0, i_readM}, 32'd0);
    tick();
    chk("first_readM", {31'd0, i_readM}, 32'd1);
    chk("first_addr", {16'd0, i_address}, 32'h0000);
    tick();
    chk("w0_valid", {31'd0, if_id_valid}, 32'd1);
    chk("w0_inst", {16'd0, if_id_inst}, 32'h6001);
    chk("w0_opcode", {28'd0, opcode}, 32'h6);
    chk("w0_func", {26'd0, func_code}, 32'h01);
    chk("w0_npc", {16'd0, if_id_npc}, 32'h0001);
    chk("w0_next_addr", {16'd0, i_address}, 32'h0001);
    chk("w0_nfetch", {16'd0, num_fetch}, 32'd1);
    tick();
    chk("w0_consumed", {31'd0, if_id_valid}, 32'd0);
    tick();
    chk("w1_inst", {16'd0, if_id_inst}, 32'h6102);
    chk("w1_pc", {16'd0, if_id_pc}, 32'h0001);
    chk("w1_nfetch", {16'd0, num_fetch}, 32'd2);
    chk("w1_next_addr", {16'd0, i_address}, 32'h0002);

    // Stall holds 6102 while the word at 0002 returns -> skid, STALLED.
    stall = 1'b1;
    tick();
    chk("stall_hold_valid", {31'd0, if_id_valid}, 32'd1);
    tick();
    chk("stalled_readM", {31'd0, i_readM}, 32'd0);
    chk("stalled_inst", {16'd0, if_id_inst}, 32'h6102);
    chk("stalled_nfetch", {16'd0, num_fetch}, 32'd2);
    tick();
    chk("stalled_readM2", {31'd0, i_readM}, 32'd0);
    stall = 1'b0;
    tick();
    chk("unstall_inst", {16'd0, if_id_inst}, 32'h6203);
    chk("unstall_pc", {16'd0, if_id_pc}, 32'h0002);
    chk("unstall_nfetch", {16'd0, num_fetch}, 32'd3);
    chk("unstall_readM", {31'd0, i_readM}, 32'd1);
    chk("unstall_addr", {16'd0, i_address}, 32'h0003);
    tick();
    chk("w3_inst", {16'd0, if_id_inst}, 32'h6304);
    chk("w3_nfetch", {16'd0, num_fetch}, 32'd4);
    tick(); tick();
    chk("w4_inst", {16'd0, if_id_inst}, 32'h6405);
    chk("w4_addr", {16'd0, i_address}, 32'h0005);

    // 3-cycle memory: redirect one cycle into the request for 0005.
    mem_lat = 3;
    tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("drain_readM", {31'd0, i_readM}, 32'd1);
    chk("drain_addr", {16'd0, i_address}, 32'h0005);
    chk("drain_valid", {31'd0, if_id_valid}, 32'd0);
    tick();
    chk("drain_addr2", {16'd0, i_address}, 32'h0005);
    tick();
    chk("post_drain_addr", {16'd0, i_address}, 32'h0040);
    chk("post_drain_valid", {31'd0, if_id_valid}, 32'd0);
    chk("post_drain_nfetch", {16'd0, num_fetch}, 32'd5);
    wait_valid(10);
    chk("w40_inst", {16'd0, if_id_inst}, 32'h6041);
    chk("w40_pc", {16'd0, if_id_pc}, 32'h0040);
    chk("w40_npc", {16'd0, if_id_npc}, 32'h0041);
    chk("w40_nfetch", {16'd0, num_fetch}, 32'd6);

    // Redirect coincident with i_ready for 0041.
    mem_lat = 1;
    tick();
    redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    redirect = 1'b0;
    chk("coinc_valid", {31'd0, if_id_valid}, 32'd0);
    chk("coinc_readM", {31'd0, i_readM}, 32'd1);
    chk("coinc_addr", {16'd0, i_address}, 32'h0080);
    chk("coinc_nfetch", {16'd0, num_fetch}, 32'd6);
    tick(); tick();
    chk("w80_inst", {16'd0, if_id_inst}, 32'h6081);
    chk("w80_pc", {16'd0, if_id_pc}, 32'h0080);
    chk("w80_nfetch", {16'd0, num_fetch}, 32'd7);

    // Halt (with stall held) while the request for 0081 is outstanding.
    mem_lat = 2;
    halt = 1'b1; stall = 1'b1;
    tick();
    halt = 1'b0; stall = 1'b0;
    chk("halt_drain_readM", {31'd0, i_readM}, 32'd1);
    chk("halt_drain_addr", {16'd0, i_address}, 32'h0081);
    chk("halt_valid", {31'd0, if_id_valid}, 32'd0);
    tick();
    chk("halt_drain_readM2", {31'd0, i_readM}, 32'd1);
    tick();
    chk("halted_readM", {31'd0, i_readM}, 32'd0);
    redirect = 1'b1; redirect_pc = 16'h00C0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halted_readM_loop", {31'd0, i_readM}, 32'd0);
      chk("halted_valid_loop", {31'd0, if_id_valid}, 32'd0);
      chk("halted_addr_loop", {16'd0, i_address}, 32'h0081);
    end
    redirect = 1'b0;
    chk("halted_nfetch", {16'd0, num_fetch}, 32'd7);

    // Reset out of HALTED, restart at RESET_PC.
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst2");
    tick();
    mem_lat = 1;
    reset_n = 1'b1;
    tick();
    chk("rst2_restart_readM", {31'd0, i_readM}, 32'd1);
    chk("rst2_restart_addr", {16'd0, i_address}, 32'h0000);
    tick();
    chk("rst2_w0_inst", {16'd0, if_id_inst}, 32'h6001);
    chk("rst2_w0_nfetch", {16'd0, num_fetch}, 32'd1);

    // Async reset in the middle of the request for 0001.
    mem_lat = 3;
    tick();
    chk("midreq_readM", {31'd0, i_readM}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk_reset_outputs("rst3");
    tick();
    mem_lat = 1;
    reset_n = 1'b1;
    chk("rst3_idle_readM", {31'd0, i_readM}, 32'd0);
    tick();
    chk("rst3_restart_readM", {31'd0, i_readM}, 32'd1);
    chk("rst3_restart_addr", {16'd0, i_address}, 32'h0000);
    tick();
    chk("rst3_w0_inst", {16'd0, if_id_inst}, 32'h6001);
    chk("rst3_w0_pc", {16'd0, if_id_pc}, 32'h0000);
    chk("rst3_w0_npc", {16'd0, if_id_npc}, 32'h0001);
    chk("rst3_w0_nfetch", {16'd0, num_fetch}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
